// File: rtl/yval_pkg.sv
// Y-matrix SRAM packing shared by the read and change-write paths:
// five 48-bit {real, img} entries per 256-bit word, top 16 bits unused.
package yval_pkg;
    localparam int ENT_W        = 48;
    localparam int PART_W       = 24;
    localparam int WORD_W       = 256;
    localparam int ENT_PER_WORD = 5;

    typedef struct packed {
        logic [15:0]       row;
        logic [15:0]       col;
        logic [PART_W-1:0] real_part;
        logic [PART_W-1:0] img_part;
    } yrec_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WT,
        ST_EM,
        ST_DN
    } yrd_state_t;

    function automatic int slot_lsb(input int slot);
        return slot * ENT_W;
    endfunction
endpackage

// File: rtl/yword_unpack.sv
// Combinational slot extract from one packed Y word; slot indices past the
// last entry read as zero.
module yword_unpack
    import yval_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    input  logic [2:0]        slot,
    output logic [PART_W-1:0] re,
    output logic [PART_W-1:0] im,
    output logic              is_zero
);
    logic [ENT_W-1:0] ent;
    logic             unused_hi;

    // upper 16 bits of the word carry no entry
    assign unused_hi = ^word[WORD_W-1:ENT_PER_WORD*ENT_W];

    always_comb begin
        ent = '0;
        for (int s = 0; s < ENT_PER_WORD; s++) begin
            if (32'(slot) == s) ent = word[slot_lsb(s) +: ENT_W];
        end
    end

    assign re      = ent[ENT_W-1:PART_W];
    assign im      = ent[PART_W-1:0];
    assign is_zero = (ent == '0);
endmodule

// File: rtl/yrow_reader.sv
// Streams the stored entries of one Y-matrix row as (row, col, real, img)
// records under valid/ready.
//   state | meaning
//   IDLE  | wait for start, reject out-of-range rows with err
//   RD    | issue one word read
//   WT    | capture the returned word
//   EM    | evaluate one slot per cycle, stall on a pending record
//   DN    | one-cycle done pulse
module yrow_reader
    import yval_pkg::*;
#(
    parameter int NUM_ROWS  = 16,
    parameter int NUM_COLS  = 16,
    parameter int BASE_ADDR = 0,
    parameter int ADDR_W    = 10,
    parameter int SKIP_ZERO = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [15:0]       req_row,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_row,
    output logic [15:0]       out_col,
    output logic [PART_W-1:0] out_real,
    output logic [PART_W-1:0] out_img,
    output logic [15:0]       ent_count
);
    localparam int WORDS_PER_ROW = (NUM_COLS + ENT_PER_WORD - 1) / ENT_PER_WORD;

    yrd_state_t        state_q, state_d;
    logic [15:0]       row_q, word_q, ent_cnt_q, cur_col;
    logic [2:0]        slot_q;
    logic [WORD_W-1:0] word_buf;
    yrec_t             rec_q;
    logic              valid_q, err_q;
    logic [PART_W-1:0] slot_re, slot_im;
    logic              slot_zero, skip, req_ok, accept, em_free, exhausted, last_word;

    yword_unpack u_unpack (
        .word    (word_buf),
        .slot    (slot_q),
        .re      (slot_re),
        .im      (slot_im),
        .is_zero (slot_zero)
    );

    assign req_ok    = {16'd0, req_row} < 32'(NUM_ROWS);
    assign accept    = (state_q == ST_IDLE) && start && req_ok;
    assign cur_col   = 16'(32'(word_q) * ENT_PER_WORD + 32'(slot_q));
    // a word is finished once past slot 4 or past the last real column
    assign exhausted = (slot_q == 3'(ENT_PER_WORD)) || ({16'd0, cur_col} >= 32'(NUM_COLS));
    assign last_word = ({16'd0, word_q} == 32'(WORDS_PER_ROW - 1));
    assign skip      = (SKIP_ZERO != 0) && slot_zero;
    assign em_free   = !valid_q || out_ready;

    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        mem_rd_en = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_RD;
            ST_RD: begin
                mem_rd_en = 1'b1;
                busy      = 1'b1;
                state_d   = ST_WT;
            end
            ST_WT: begin
                busy    = 1'b1;
                state_d = ST_EM;
            end
            ST_EM: begin
                busy = 1'b1;
                // leave only after the last record of the word has transferred
                if (em_free && exhausted) state_d = last_word ? ST_DN : ST_RD;
            end
            ST_DN: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mem_addr = mem_rd_en ? ADDR_W'(BASE_ADDR) + ADDR_W'(32'(row_q) * WORDS_PER_ROW)
                                  + ADDR_W'(word_q)
                                : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            row_q     <= '0;
            word_q    <= '0;
            slot_q    <= '0;
            word_buf  <= '0;
            rec_q     <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            ent_cnt_q <= '0;
        end else begin
            err_q <= (state_q == ST_IDLE) && start && !req_ok;
            case (state_q)
                ST_IDLE: if (accept) begin
                    row_q     <= req_row;
                    word_q    <= '0;
                    ent_cnt_q <= '0;
                end
                ST_WT: begin
                    word_buf <= mem_rdata;
                    slot_q   <= '0;
                end
                ST_EM: if (em_free) begin
                    if (valid_q) ent_cnt_q <= ent_cnt_q + 16'd1;
                    if (exhausted) begin
                        valid_q <= 1'b0;
                        word_q  <= word_q + 16'd1;
                    end else begin
                        slot_q          <= slot_q + 3'd1;
                        valid_q         <= !skip;
                        rec_q.row       <= row_q;
                        rec_q.col       <= cur_col;
                        rec_q.real_part <= slot_re;
                        rec_q.img_part  <= slot_im;
                    end
                end
                default: ;
            endcase
        end
    end

    assign err       = err_q;
    assign out_valid = valid_q;
    assign out_row   = rec_q.row;
    assign out_col   = rec_q.col;
    assign out_real  = rec_q.real_part;
    assign out_img   = rec_q.img_part;
    assign ent_count = ent_cnt_q;
endmodule
